// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with synchronous load and wrap/saturate ends.
// Define GRAY_COUNTER_CHECK_EN to build in the sticky single-bit-change checker behind err_out.
module gray_counter #(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         tc,
    output logic         err_out
);

    localparam logic [N-1:0] ALL_ONES = '1;
    localparam logic [N-1:0] ZERO     = '0;
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        logic [N-1:0] g;
        g[N-1] = b[N-1];
        for (int i = 0; i < N - 1; i++) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         tc_q, tc_d;

    // Load wins over counting; load_bin is only looked at when load is high.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (bin_q == ALL_ONES) begin
                    tc_d  = 1'b1;
                    bin_d = WRAP ? ZERO : ALL_ONES;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    tc_d  = 1'b1;
                    bin_d = WRAP ? ALL_ONES : ZERO;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
    end

    // Gray is encoded from the next binary value so both registers always agree.
    always_comb begin
        gray_d = to_gray(bin_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;

`ifdef GRAY_COUNTER_CHECK_EN
    logic [N-1:0] prev_gray_q, prev_gray_d;
    logic         chk_q, chk_d;
    logic         err_q, err_d;
    logic [N-1:0] diff;
    int           dist;

    // chk_q marks that gray_q was just produced by a real count step.
    always_comb begin
        prev_gray_d = gray_q;
        chk_d       = en && !load && (bin_d != bin_q);
        diff        = gray_q ^ prev_gray_q;
        dist        = 0;
        for (int i = 0; i < N; i++) begin
            dist = dist + int'(diff[i]);
        end
        err_d = err_q;
        if (chk_q && (dist != 1)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray_q <= '0;
            chk_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_gray_q <= prev_gray_d;
            chk_q       <= chk_d;
            err_q       <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed vector bench for gray_counter: N=4 wrap, N=4 saturate, N=8 random against a model.
module tb_gray_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_en = 0, a_up = 0, a_load = 0;
    logic [3:0] a_lb = 0;
    logic [3:0] a_bin, a_gray;
    logic       a_tc, a_err;

    logic       b_en = 0, b_up = 0, b_load = 0;
    logic [3:0] b_lb = 0;
    logic [3:0] b_bin, b_gray;
    logic       b_tc, b_err;

    logic       c_en = 0, c_up = 0, c_load = 0;
    logic [7:0] c_lb = 0;
    logic [7:0] c_bin, c_gray;
    logic       c_tc, c_err;

    gray_counter #(.N(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .load(a_load), .load_bin(a_lb),
        .bin_out(a_bin), .gray_out(a_gray), .tc(a_tc), .err_out(a_err));

    gray_counter #(.N(4), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .load(b_load), .load_bin(b_lb),
        .bin_out(b_bin), .gray_out(b_gray), .tc(b_tc), .err_out(b_err));

    gray_counter #(.N(8), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(c_up), .load(c_load), .load_bin(c_lb),
        .bin_out(c_bin), .gray_out(c_gray), .tc(c_tc), .err_out(c_err));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gray8(input logic [7:0] b);
        logic [7:0] g;
        g[7] = b[7];
        for (int i = 0; i < 7; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    typedef struct {
        logic       sel_b;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lb;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       tc;
    } vec_t;

    vec_t vecs[24];
    int   nvec = 0;

    task automatic add(input logic sel_b, input logic load, input logic en, input logic up,
                       input logic [3:0] lb, input logic [3:0] bin, input logic [3:0] gray,
                       input logic tc);
        vecs[nvec] = '{sel_b, load, en, up, lb, bin, gray, tc};
        nvec++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sweep_gray [17];
    logic [7:0] m_bin;
    logic       m_tc;
    logic [7:0] forced_val;

    initial begin
        sweep_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                       4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        // sel load en up lb   bin  gray tc
        add(0, 1, 0, 0, 4'h1, 4'h1, 4'h1, 0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0);
        add(0, 0, 1, 0, 4'h0, 4'hF, 4'h8, 1);
        add(0, 0, 1, 0, 4'h0, 4'hE, 4'h9, 0);
        add(0, 1, 1, 1, 4'h5, 4'h5, 4'h7, 0);
        add(0, 0, 0, 1, 4'hA, 4'h5, 4'h7, 0);
        add(0, 0, 1, 1, 4'h3, 4'h6, 4'h5, 0);
        add(0, 0, 1, 0, 4'h3, 4'h5, 4'h7, 0);
        add(0, 1, 0, 0, 4'hF, 4'hF, 4'h8, 0);
        add(0, 0, 1, 1, 4'h2, 4'h0, 4'h0, 1);
        add(0, 0, 0, 0, 4'h2, 4'h0, 4'h0, 0);
        add(1, 1, 0, 0, 4'hE, 4'hE, 4'h9, 0);
        add(1, 0, 1, 1, 4'h0, 4'hF, 4'h8, 0);
        add(1, 0, 1, 1, 4'h0, 4'hF, 4'h8, 1);
        add(1, 0, 1, 1, 4'h0, 4'hF, 4'h8, 1);
        add(1, 0, 1, 1, 4'h0, 4'hF, 4'h8, 1);
        add(1, 0, 1, 0, 4'h0, 4'hE, 4'h9, 0);
        add(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0);
        add(1, 0, 1, 0, 4'h7, 4'h0, 4'h0, 1);
        add(1, 0, 1, 1, 4'h7, 4'h1, 4'h1, 0);
        add(1, 0, 0, 1, 4'h7, 4'h1, 4'h1, 0);

        // Reset state
        tick();
        tick();
        check("rst_a_bin", 8'(a_bin), 8'h0);
        check("rst_a_gray", 8'(a_gray), 8'h0);
        check("rst_a_tc", 8'(a_tc), 8'h0);
        check("rst_c_bin", c_bin, 8'h0);
        @(negedge clk);
        rst = 1'b0;

        // Up sweep through the wrap
        @(posedge clk);
        #1;
        a_en = 1; a_up = 1;
        check("sweep_gray_0", 8'(a_gray), 8'(sweep_gray[0]));
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("sweep_bin", 8'(a_bin), 8'(i % 16));
            check("sweep_gray", 8'(a_gray), 8'(sweep_gray[i]));
            check("sweep_tc", 8'(a_tc), (i == 16) ? 8'h1 : 8'h0);
            check("sweep_err", 8'(a_err), 8'h0);
        end

        // Async reset mid-count from 9
        a_en = 0; a_load = 1; a_lb = 4'h8;
        tick();
        a_load = 0; a_en = 1; a_up = 1;
        tick();
        a_en = 0;
        check("pre_rst_bin", 8'(a_bin), 8'h9);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_bin", 8'(a_bin), 8'h0);
        check("async_rst_gray", 8'(a_gray), 8'h0);
        check("async_rst_tc", 8'(a_tc), 8'h0);
        check("async_rst_err", 8'(a_err), 8'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table vectors
        for (int v = 0; v < nvec; v++) begin
            if (vecs[v].sel_b) begin
                a_en = 0; a_load = 0;
                b_load = vecs[v].load; b_en = vecs[v].en; b_up = vecs[v].up; b_lb = vecs[v].lb;
            end else begin
                b_en = 0; b_load = 0;
                a_load = vecs[v].load; a_en = vecs[v].en; a_up = vecs[v].up; a_lb = vecs[v].lb;
            end
            tick();
            if (vecs[v].sel_b) begin
                check($sformatf("vec%0d_bin", v), 8'(b_bin), 8'(vecs[v].bin));
                check($sformatf("vec%0d_gray", v), 8'(b_gray), 8'(vecs[v].gray));
                check($sformatf("vec%0d_tc", v), 8'(b_tc), 8'(vecs[v].tc));
            end else begin
                check($sformatf("vec%0d_bin", v), 8'(a_bin), 8'(vecs[v].bin));
                check($sformatf("vec%0d_gray", v), 8'(a_gray), 8'(vecs[v].gray));
                check($sformatf("vec%0d_tc", v), 8'(a_tc), 8'(vecs[v].tc));
            end
        end
        a_en = 0; a_load = 0; b_en = 0; b_load = 0;
        check("b_err_idle", 8'(b_err), 8'h0);

        // Random N=8 run against a reference model
        m_bin = 8'h0;
        m_tc  = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            c_load = ($urandom_range(0, 15) == 0);
            c_en   = ($urandom_range(0, 3) != 0);
            c_up   = 1'($urandom_range(0, 1));
            c_lb   = 8'($urandom_range(0, 255));
            tick();
            m_tc = 1'b0;
            if (c_load) begin
                m_bin = c_lb;
            end else if (c_en) begin
                if (c_up) begin
                    m_tc  = (m_bin == 8'hFF);
                    m_bin = m_bin + 8'h1;
                end else begin
                    m_tc  = (m_bin == 8'h00);
                    m_bin = m_bin - 8'h1;
                end
            end
            check("rand_bin", c_bin, m_bin);
            check("rand_gray", c_gray, gray8(m_bin));
            check("rand_tc", 8'(c_tc), 8'(m_tc));
            check("rand_err", 8'(c_err), 8'h0);
        end

`ifdef GRAY_COUNTER_CHECK_EN
        // Corrupt one Gray bit right after a step; the checker must latch it
        c_load = 0; c_en = 1; c_up = 1;
        tick();
        c_en = 0;
        forced_val = c_gray ^ 8'h08;
        force dut_c.gray_q = forced_val;
        tick();
        release dut_c.gray_q;
        check("fault_err_set", 8'(c_err), 8'h1);
        tick();
        check("fault_err_sticky", 8'(c_err), 8'h1);
        tick();
        check("fault_err_sticky2", 8'(c_err), 8'h1);
        rst = 1'b1;
        #1;
        check("fault_err_cleared", 8'(c_err), 8'h0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
